prog_clock_divider: RTL and testbench
=====================================

# prog_clock_divider

Multi-channel, runtime-programmable clock divider for the pedestrian traffic-light design. It generates CH_N independent, glitch-free, 50%-duty divided clocks plus one-cycle tick strobes from the board clock, so one block replaces the per-rate fixed dividers. Each channel's half-period is reloaded at run time through a valid/ready config port and applied only at that channel's period boundary. The countdown, blink and phase FSMs consume `tick` as an enable.

## Interface
- CH_N, 2, number of independent channels (≥1)
- CNT_W, 25, counter / half-period width
- DIV_DEFAULT, 24000000, reset half-period in clk cycles (1 ≤ DIV_DEFAULT ≤ 2^CNT_W−1), same for all channels
- clk  in  1  single system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  CH_N  per-channel run enable
- sync_clr  in  1  restart all channels phase-aligned
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted this cycle
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(CH_N))
- cfg_half  in  CNT_W  new half-period in cycles
- divided_clk  out  CH_N  divided square wave, period 2·H cycles
- tick  out  CH_N  one-cycle strobe on each rising edge of divided_clk

## Operation
- Per channel registers: cnt[CNT_W], half[CNT_W], pend_half[CNT_W], pend flag, divided_clk, tick.
- Enabled cycle, cnt != half−1: cnt += 1.
- Enabled cycle, cnt == half−1 (terminal):
  - cnt ← 0 and divided_clk toggles.
  - tick ← 1 iff divided_clk goes 0→1, else tick ← 0.
  - If pend: half ← pend_half, pend ← 0.
- en low: cnt, divided_clk and half hold; tick ← 0; pending config stays pending.
- Config accept = cfg_valid && cfg_ready.
  - cfg_ready = !sync_clr && !(cfg_ch < CH_N && pend[cfg_ch]).
  - cfg_half == 0 is stored as 1.
  - cfg_ch ≥ CH_N: accepted and dropped.
- Accept in the same cycle as a terminal count of the same channel: the new value loads directly into half at that edge; pend is not set.
- Otherwise an accept sets pend_half and pend; the current period completes with the old half.
- sync_clr, all channels:
  - cnt ← 0, divided_clk ← 0, tick ← 0.
  - Any pend applied to half immediately; pend ← 0.
  - Config is not accepted in that cycle.
- Priority: rst > sync_clr > config/terminal > count.
- Arithmetic: cnt compares against half−1 computed at CNT_W bits. half ≥ 1 always, so no underflow. cnt never exceeds half−1, so no wrap beyond terminal.

## Timing
- Reset values:
  - cnt 0, half DIV_DEFAULT, pend 0.
  - divided_clk 0, tick 0.
  - cfg_ready 1, once rst is low and sync_clr is low.
- rst mid-operation: reset values at the next edge; any pending config is discarded.
- With en held high from the first cycle after reset, divided_clk first rises at the end of cycle H. It then toggles every H cycles.
- tick is registered: high in exactly the cycles where divided_clk has just become 1. One cycle wide, once per 2·H cycles.
- H = 1: divided_clk toggles every cycle; tick high every other cycle.
- New half: takes effect from the first period that starts after the next terminal count, or immediately when the accept coincides with a terminal count. No output glitch or short pulse ever occurs.
- cfg_ready is combinational from pend, sync_clr and cfg_ch. cfg_valid may depend on cfg_ready.

## Structure
- Package `prog_clock_divider_pkg`: CNT_W and DIV_DEFAULT defaults, and the CH_W derivation function.
- Sub-module `divider_channel`: one counter/pend/output slice with ports clk, rst, en, sync_clr, load_now, load_pend, load_val, divided_clk, tick, pend.
- Top instantiates CH_N slices, decodes cfg_ch and generates cfg_ready.

## Test plan
- Reset, DIV_DEFAULT=3, CH_N=2, en=2'b11:
  - divided_clk toggles every 3 cycles.
  - tick high on cycles 3, 9, 15 after reset release.
  - Both channels identical.
- Channel 1 at H=3, cnt=1: accept cfg_half=5.
  - The current half-period ends at H=3.
  - Subsequent toggles every 5 cycles.
  - Channel 0 is unaffected.
- A second cfg to ch1 while pend[1]=1 sees cfg_ready=0.
  - The held request is accepted the cycle after the terminal count.
  - A cfg to ch0 in the same interval is accepted immediately.
- en[0] low at cnt=1 for 7 cycles:
  - divided_clk[0] and cnt hold, tick 0.
  - After re-enable, the next toggle follows 2 enabled cycles later.
- Channels at different phases, pend set on ch0, sync_clr for 1 cycle:
  - All outputs 0 and cnt 0 next cycle; cfg_ready 0 during sync_clr.
  - Ch0 runs with the pending value.
  - Channels with equal H toggle in lockstep thereafter.
- rst pulsed mid-period with pend set:
  - The next edge gives divided_clk 0, tick 0, half = DIV_DEFAULT and pend cleared.
  - cfg_half=0 accepted afterwards behaves as H=1.

Source files
------------

// File: rtl/prog_clock_divider_pkg.sv
// prog_clock_divider_pkg: shared defaults and channel-select width helper
package prog_clock_divider_pkg;
  localparam int CNT_W_DEF = 25;
  localparam int DIV_DEFAULT_DEF = 24000000;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/divider_channel.sv
// divider_channel: one programmable 50%-duty divider slice with pending half-period reload
module divider_channel
  import prog_clock_divider_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             load_now,
  input  logic             load_pend,
  input  logic [CNT_W-1:0] load_val,
  output logic             divided_clk,
  output logic             tick,
  output logic             pend
);
  logic [CNT_W-1:0] cnt_q, cnt_d, half_q, half_d, pend_half_q, pend_half_d, half_m1;
  logic             clk_q, clk_d, tick_q, tick_d, pend_q, pend_d, term;
  assign half_m1 = half_q - CNT_W'(1);
  assign term = en && (cnt_q == half_m1);
  always_comb begin
    cnt_d = cnt_q;
    half_d = half_q;
    pend_half_d = pend_half_q;
    pend_d = pend_q;
    clk_d = clk_q;
    tick_d = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
      clk_d = 1'b0;
      half_d = (load_now && pend_q) ? pend_half_q : half_q;
      pend_d = 1'b0;
    end else begin
      if (en) begin
        cnt_d = term ? '0 : cnt_q + CNT_W'(1);
        clk_d = clk_q ^ term;
        tick_d = term && !clk_q;
      end
      if (term && pend_q) begin
        half_d = pend_half_q;
        pend_d = 1'b0;
      end
      // a write landing on the terminal edge bypasses the pending slot
      if (load_pend && term) half_d = load_val;
      else if (load_pend) begin
        pend_half_d = load_val;
        pend_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      half_q <= CNT_W'(DIV_DEFAULT);
      pend_half_q <= '0;
      pend_q <= 1'b0;
      clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      half_q <= half_d;
      pend_half_q <= pend_half_d;
      pend_q <= pend_d;
      clk_q <= clk_d;
      tick_q <= tick_d;
    end
  end
  assign divided_clk = clk_q;
  assign tick = tick_q;
  assign pend = pend_q;
endmodule

// File: rtl/prog_clock_divider.sv
// prog_clock_divider: CH_N runtime-programmable divided clocks with tick strobes
module prog_clock_divider
  import prog_clock_divider_pkg::*;
#(
  parameter int CH_N = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF,
  parameter int CH_W = ch_w(CH_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH_N-1:0]  en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_half,
  output logic [CH_N-1:0]  divided_clk,
  output logic [CH_N-1:0]  tick
);
  logic [CH_N-1:0]  pend;
  logic [CNT_W-1:0] load_val;
  logic             blk, fire;
  assign load_val = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign fire = cfg_valid && cfg_ready;
  // out-of-range channels never match, so such requests are accepted and dropped
  always_comb begin
    blk = 1'b0;
    for (int j = 0; j < CH_N; j++) blk = blk | (pend[j] && (cfg_ch == CH_W'(j)));
    cfg_ready = !sync_clr && !blk;
  end
  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    divider_channel #(.CNT_W(CNT_W), .DIV_DEFAULT(DIV_DEFAULT)) u_ch (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .sync_clr(sync_clr),
      .load_now(sync_clr),
      .load_pend(fire && (cfg_ch == CH_W'(i))),
      .load_val(load_val),
      .divided_clk(divided_clk[i]),
      .tick(tick[i]),
      .pend(pend[i])
    );
  end
endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;
  logic       clk = 1'b0;
  logic       rst, sync_clr, cfg_valid, cfg_ready;
  logic [1:0] en, divided_clk, tick;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_half;
  int         pass_cnt = 0;
  int         total = 0;
  prog_clock_divider #(.CH_N(2), .CNT_W(8), .DIV_DEFAULT(3)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_clr(sync_clr), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_half(cfg_half),
    .divided_clk(divided_clk), .tick(tick)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1; sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_half = 8'd0; en = 2'b11;
    step;
    step;
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset;
    logic [1:0] ed, et;
    do_reset;
    total++;
    if ({tick, divided_clk} !== 4'b0000) $display("FAIL reset_outputs got %b exp 0000", {tick, divided_clk});
    else pass_cnt++;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cfg_ready);
    else pass_cnt++;
    for (int k = 1; k <= 16; k++) begin
      step;
      ed = ((k / 3) % 2) ? 2'b11 : 2'b00;
      et = (k % 6 == 3) ? 2'b11 : 2'b00;
      total++;
      if ({tick, divided_clk} !== {et, ed}) $display("FAIL reset_wave k=%0d got %b exp %b", k, {tick, divided_clk}, {et, ed});
      else pass_cnt++;
    end
  endtask
  task automatic test_cfg_midperiod;
    logic ed0, et0, ed1, et1;
    do_reset;
    step;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd5;
    #1;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle got %b exp 1", cfg_ready);
    else pass_cnt++;
    step;
    cfg_valid = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL cfg_ready_pend got %b exp 0", cfg_ready);
    else pass_cnt++;
    for (int k = 3; k <= 14; k++) begin
      step;
      ed1 = (k >= 3 && k < 8) || k >= 13;
      et1 = (k == 3) || (k == 13);
      ed0 = ((k / 3) % 2) == 1;
      et0 = (k % 6 == 3);
      total++;
      if ({tick, divided_clk} !== {et1, et0, ed1, ed0}) $display("FAIL cfg_mid_wave k=%0d got %b exp %b", k, {tick, divided_clk}, {et1, et0, ed1, ed0});
      else pass_cnt++;
    end
  endtask
  task automatic test_back_to_back;
    logic ed0, ed1, et1;
    do_reset;
    step;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd4;
    step;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL b2b_ch1_blocked got %b exp 0", cfg_ready);
    else pass_cnt++;
    cfg_ch = 1'b0; cfg_half = 8'd6;
    #1;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL b2b_ch0_ready got %b exp 1", cfg_ready);
    else pass_cnt++;
    step;
    cfg_ch = 1'b1; cfg_half = 8'd2;
    #1;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL b2b_ch1_after_term got %b exp 1", cfg_ready);
    else pass_cnt++;
    step;
    cfg_valid = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL b2b_ch1_pend_again got %b exp 0", cfg_ready);
    else pass_cnt++;
    cfg_ch = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b1) $display("FAIL b2b_ch0_direct_load got %b exp 1", cfg_ready);
    else pass_cnt++;
    for (int k = 5; k <= 14; k++) begin
      step;
      ed0 = (k >= 3 && k < 9);
      ed1 = (k < 7) || (k >= 9 && k < 11) || k >= 13;
      et1 = (k == 9) || (k == 13);
      total++;
      if ({tick, divided_clk} !== {et1, 1'b0, ed1, ed0}) $display("FAIL b2b_wave k=%0d got %b exp %b", k, {tick, divided_clk}, {et1, 1'b0, ed1, ed0});
      else pass_cnt++;
    end
  endtask
  task automatic test_enable;
    do_reset;
    step;
    en = 2'b10;
    for (int k = 2; k <= 8; k++) begin
      step;
      total++;
      if ({tick[0], divided_clk[0], divided_clk[1]} !== {2'b00, ((k / 3) % 2) == 1}) $display("FAIL en_hold k=%0d got %b exp %b", k, {tick[0], divided_clk[0], divided_clk[1]}, {2'b00, ((k / 3) % 2) == 1});
      else pass_cnt++;
    end
    en = 2'b11;
    step;
    total++;
    if ({tick[0], divided_clk[0]} !== 2'b00) $display("FAIL en_resume1 got %b exp 00", {tick[0], divided_clk[0]});
    else pass_cnt++;
    step;
    total++;
    if ({tick[0], divided_clk[0]} !== 2'b11) $display("FAIL en_resume2 got %b exp 11", {tick[0], divided_clk[0]});
    else pass_cnt++;
  endtask
  task automatic test_sync_clr;
    logic ed0, ed1;
    do_reset;
    en = 2'b01;
    step;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd4;
    step;
    en = 2'b11; sync_clr = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd7;
    #1;
    total++;
    if (cfg_ready !== 1'b0) $display("FAIL sync_ready got %b exp 0", cfg_ready);
    else pass_cnt++;
    step;
    sync_clr = 1'b0; cfg_valid = 1'b0; cfg_ch = 1'b0;
    #1;
    total++;
    if ({tick, divided_clk, cfg_ready} !== 5'b00001) $display("FAIL sync_clear got %b exp 00001", {tick, divided_clk, cfg_ready});
    else pass_cnt++;
    for (int k = 4; k <= 10; k++) begin
      step;
      ed0 = (k >= 7);
      ed1 = (k >= 6 && k < 9);
      total++;
      if ({tick, divided_clk} !== {k == 6, k == 7, ed1, ed0}) $display("FAIL sync_wave k=%0d got %b exp %b", k, {tick, divided_clk}, {k == 6, k == 7, ed1, ed0});
      else pass_cnt++;
    end
  endtask
  task automatic test_rst_mid;
    logic ed0, ed1;
    do_reset;
    step;
    step;
    step;
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_half = 8'd5;
    step;
    cfg_valid = 1'b0;
    #1;
    total++;
    if ({cfg_ready, divided_clk} !== 3'b011) $display("FAIL rst_pre got %b exp 011", {cfg_ready, divided_clk});
    else pass_cnt++;
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    total++;
    if ({tick, divided_clk, cfg_ready} !== 5'b00001) $display("FAIL rst_mid got %b exp 00001", {tick, divided_clk, cfg_ready});
    else pass_cnt++;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_half = 8'd0;
    step;
    cfg_valid = 1'b0;
    for (int k = 2; k <= 7; k++) begin
      step;
      ed0 = (k >= 3) && (k % 2 == 1);
      ed1 = (k >= 3 && k < 6);
      total++;
      if ({tick, divided_clk} !== {k == 3, ed0, ed1, ed0}) $display("FAIL rst_h1_wave k=%0d got %b exp %b", k, {tick, divided_clk}, {k == 3, ed0, ed1, ed0});
      else pass_cnt++;
    end
  endtask
  initial begin
    test_reset;
    test_cfg_midperiod;
    test_back_to_back;
    test_enable;
    test_sync_clr;
    test_rst_mid;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
